// File: rtl/commutator_pkg.sv
// Shared constants and helpers for the commutator_scan block.
package commutator_pkg;

    localparam logic MODE_STATIC = 1'b0;
    localparam logic MODE_SCAN   = 1'b1;

    // Channel-address width: a single output channel still needs a 1-bit address.
    function automatic int ch_width(input int n_out);
        return (n_out <= 1) ? 1 : $clog2(n_out);
    endfunction

endpackage

// File: rtl/commutator_scan_if.sv
// Select-write / commit handshake bundle between the host and commutator_scan.
interface commutator_scan_if #(
    parameter int N_IN  = 8,
    parameter int N_OUT = 3
);
    import commutator_pkg::*;

    localparam int SEL_W = $clog2(N_IN);
    localparam int CH_W  = ch_width(N_OUT);

    logic             cfg_valid;
    logic             cfg_ready;
    logic [CH_W-1:0]  cfg_ch;
    logic [SEL_W-1:0] cfg_sel;
    logic             commit;
    logic             cfg_err;

    modport master (
        output cfg_valid, cfg_ch, cfg_sel, commit,
        input  cfg_ready, cfg_err
    );

    modport slave (
        input  cfg_valid, cfg_ch, cfg_sel, commit,
        output cfg_ready, cfg_err
    );

endinterface

// File: rtl/commutator_mux.sv
// Combinational N_IN-to-1 bit selector; an out-of-range select yields 0.
module commutator_mux #(
    parameter  int N_IN  = 8,
    localparam int SEL_W = $clog2(N_IN)
) (
    input  logic [N_IN-1:0]  data,
    input  logic [SEL_W-1:0] sel,
    output logic             y
);

    always_comb begin
        y = 1'b0;
        for (int i = 0; i < N_IN; i++) begin
            if (sel == SEL_W'(i)) y = data[i];
        end
    end

endmodule

// File: rtl/commutator_scan.sv
// N_IN-to-N_OUT commutator with shadow/active select banks, atomic commit
// and an optional dwell-timed scan that advances all selects together.
module commutator_scan
    import commutator_pkg::*;
#(
    parameter  int N_IN    = 8,
    parameter  int N_OUT   = 3,
    parameter  int DWELL_W = 8,
    localparam int SEL_W   = $clog2(N_IN),
    localparam int CH_W    = ch_width(N_OUT)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [N_IN-1:0]        inputs,
    commutator_scan_if.slave       cfg,
    input  logic                   mode,
    input  logic [DWELL_W-1:0]     dwell,
    output logic [N_OUT-1:0]       outputs,
    output logic [N_OUT*SEL_W-1:0] active_sel,
    output logic                   scan_wrap
);

    localparam logic [SEL_W-1:0] LAST_SEL  = SEL_W'(N_IN - 1);
    localparam logic [CH_W:0]    N_OUT_LIM = (CH_W + 1)'(N_OUT);
    localparam logic [SEL_W:0]   N_IN_LIM  = (SEL_W + 1)'(N_IN);

    logic               apply_reg;
    logic               cfg_err_reg;
    logic               scan_wrap_reg;
    logic [DWELL_W-1:0] cnt_reg, cnt_next;
    logic               wr_fire, wr_ok, ch_ok, sel_ok;
    logic               scan_on, dwell_hit, step;

    // Ready drops only for the apply cycle following a commit.
    assign cfg.cfg_ready = ~rst & ~apply_reg;
    assign wr_fire       = cfg.cfg_valid & cfg.cfg_ready;
    assign ch_ok         = {1'b0, cfg.cfg_ch} < N_OUT_LIM;
    assign sel_ok        = {1'b0, cfg.cfg_sel} < N_IN_LIM;
    assign wr_ok         = wr_fire & ch_ok & sel_ok;

    assign scan_on   = (mode == MODE_SCAN);
    assign dwell_hit = (cnt_reg >= dwell);
    // Commit takes priority over a coincident scan step.
    assign step      = scan_on & ~cfg.commit & dwell_hit;

    always_comb begin
        cnt_next = cnt_reg + 1'b1;
        if (!scan_on || cfg.commit || dwell_hit) cnt_next = '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            apply_reg     <= 1'b0;
            cfg_err_reg   <= 1'b0;
            scan_wrap_reg <= 1'b0;
            cnt_reg       <= '0;
        end else begin
            apply_reg     <= cfg.commit;
            cfg_err_reg   <= wr_fire & ~(ch_ok & sel_ok);
            scan_wrap_reg <= step & (active_sel[SEL_W-1:0] == LAST_SEL);
            cnt_reg       <= cnt_next;
        end
    end

    assign cfg.cfg_err = cfg_err_reg;
    assign scan_wrap   = scan_wrap_reg;

    genvar gi;
    generate
        for (gi = 0; gi < N_OUT; gi++) begin : g_ch
            localparam logic [SEL_W-1:0] RST_SEL = SEL_W'(gi % N_IN);

            logic [SEL_W-1:0] shadow_reg, shadow_next;
            logic [SEL_W-1:0] active_reg, active_next;
            logic             mux_out;
            logic             out_reg;

            // Commit loads shadow_next so a same-cycle write is included.
            always_comb begin
                shadow_next = shadow_reg;
                if (wr_ok && cfg.cfg_ch == CH_W'(gi)) shadow_next = cfg.cfg_sel;
                active_next = active_reg;
                if (cfg.commit)
                    active_next = shadow_next;
                else if (step)
                    active_next = (active_reg == LAST_SEL) ? '0 : active_reg + 1'b1;
            end

            always_ff @(posedge clk) begin
                if (rst) begin
                    shadow_reg <= RST_SEL;
                    active_reg <= RST_SEL;
                    out_reg    <= 1'b0;
                end else begin
                    shadow_reg <= shadow_next;
                    active_reg <= active_next;
                    out_reg    <= mux_out;
                end
            end

            commutator_mux #(.N_IN(N_IN)) u_mux (
                .data (inputs),
                .sel  (active_reg),
                .y    (mux_out)
            );

            assign outputs[gi]                    = out_reg;
            assign active_sel[gi*SEL_W +: SEL_W]  = active_reg;
        end
    endgenerate

endmodule

// File: tb/tb_commutator_scan.sv
// Directed bench for commutator_scan: an 8-input and a 5-input instance share
// clock, reset, mode and dwell; expected values are worked out by hand.
module tb_commutator_scan;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] in8;
    logic [4:0] in5;
    logic       mode;
    logic [7:0] dwell;
    logic [2:0] out8, out5;
    logic [8:0] sel8, sel5;
    logic       wrap8, wrap5;

    int n_vec = 0;
    int n_mis = 0;

    commutator_scan_if #(.N_IN(8), .N_OUT(3)) cfg8 ();
    commutator_scan_if #(.N_IN(5), .N_OUT(3)) cfg5 ();

    commutator_scan #(.N_IN(8), .N_OUT(3), .DWELL_W(8)) dut8 (
        .clk(clk), .rst(rst), .inputs(in8), .cfg(cfg8.slave), .mode(mode),
        .dwell(dwell), .outputs(out8), .active_sel(sel8), .scan_wrap(wrap8)
    );

    commutator_scan #(.N_IN(5), .N_OUT(3), .DWELL_W(8)) dut5 (
        .clk(clk), .rst(rst), .inputs(in5), .cfg(cfg5.slave), .mode(mode),
        .dwell(dwell), .outputs(out5), .active_sel(sel5), .scan_wrap(wrap5)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end else begin
            $display("ok   %s: %0d", tag, got);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] bank(input int a0, input int a1, input int a2);
        return 32'(a0 + (a1 << 3) + (a2 << 6));
    endfunction

    initial begin
        rst = 1'b1; in8 = '0; in5 = '0; mode = 1'b0; dwell = '0;
        cfg8.cfg_valid = 0; cfg8.cfg_ch = '0; cfg8.cfg_sel = '0; cfg8.commit = 0;
        cfg5.cfg_valid = 0; cfg5.cfg_ch = '0; cfg5.cfg_sel = '0; cfg5.commit = 0;

        // Reset state
        tick(); tick();
        check("rst_sel8", sel8, bank(0, 1, 2));
        check("rst_sel5", sel5, bank(0, 1, 2));
        check("rst_out8", out8, 0);
        check("rst_ready", cfg8.cfg_ready, 0);
        check("rst_err", cfg8.cfg_err, 0);
        check("rst_wrap", wrap8, 0);

        in8 = 8'b0000_0101; rst = 1'b0;
        #1 check("ready_after_rst", cfg8.cfg_ready, 1);
        tick();
        check("first_out", out8, 3'b101);

        // Writes land in shadow only
        in8 = 8'hC0;
        cfg8.cfg_valid = 1; cfg8.cfg_ch = 2'd1; cfg8.cfg_sel = 3'd6;
        tick();
        cfg8.cfg_ch = 2'd2; cfg8.cfg_sel = 3'd7;
        tick();
        cfg8.cfg_valid = 0;
        tick();
        check("nocommit_sel", sel8, bank(0, 1, 2));
        check("nocommit_out", out8, 3'b000);
        cfg8.commit = 1;
        tick();
        cfg8.commit = 0;
        check("commit_sel", sel8, bank(0, 6, 7));
        check("apply_ready", cfg8.cfg_ready, 0);
        check("commit_out_lag", out8, 3'b000);
        tick();
        check("commit_out", out8, 3'b110);
        check("ready_back", cfg8.cfg_ready, 1);

        // Rejected writes: channel 3 on dut8, select 6 on the 5-input dut5
        cfg8.cfg_valid = 1; cfg8.cfg_ch = 2'd3; cfg8.cfg_sel = 3'd1;
        cfg5.cfg_valid = 1; cfg5.cfg_ch = 2'd0; cfg5.cfg_sel = 3'd6;
        tick();
        cfg8.cfg_valid = 0; cfg5.cfg_valid = 0;
        check("err_ch", cfg8.cfg_err, 1);
        check("err_sel", cfg5.cfg_err, 1);
        tick();
        check("err_pulse8", cfg8.cfg_err, 0);
        check("err_pulse5", cfg5.cfg_err, 0);
        cfg8.commit = 1; cfg5.commit = 1;
        tick();
        cfg8.commit = 0; cfg5.commit = 0;
        check("err_keep8", sel8, bank(0, 6, 7));
        check("err_keep5", sel5, bank(0, 1, 2));
        tick();

        // Write and commit in the same cycle
        cfg8.cfg_valid = 1; cfg8.cfg_ch = 2'd0; cfg8.cfg_sel = 3'd4; cfg8.commit = 1;
        tick();
        cfg8.cfg_valid = 0; cfg8.commit = 0;
        check("bypass_sel", sel8, bank(4, 6, 7));

        // Scan, dwell=2, both widths from {2,1,0}
        rst = 1; tick(); rst = 0;
        mode = 1; dwell = 8'd2;
        for (int t = 1; t <= 24; t++) begin
            int s;
            tick();
            s = t / 3;
            check($sformatf("scan8_t%0d", t), sel8, bank(s % 8, (1 + s) % 8, (2 + s) % 8));
            check($sformatf("scan5_t%0d", t), sel5, bank(s % 5, (1 + s) % 5, (2 + s) % 5));
            check($sformatf("wrap8_t%0d", t), wrap8, (t % 3 == 0 && s % 8 == 0) ? 1 : 0);
            check($sformatf("wrap5_t%0d", t), wrap5, (t % 3 == 0 && s % 5 == 0) ? 1 : 0);
        end

        // Commit on a step cycle wins; counter restarts
        cfg8.cfg_valid = 1; cfg8.cfg_ch = 2'd0; cfg8.cfg_sel = 3'd5;
        tick();
        cfg8.cfg_valid = 0;
        tick();
        cfg8.commit = 1;
        tick();
        cfg8.commit = 0;
        check("step_commit", sel8, bank(5, 1, 2));
        tick(); tick();
        check("after_commit_hold", sel8, bank(5, 1, 2));
        tick();
        check("after_commit_step", sel8, bank(6, 2, 3));

        // Leaving scan freezes the bank
        mode = 0;
        tick(); tick(); tick(); tick();
        check("freeze", sel8, bank(6, 2, 3));

        // Reset mid-dwell with a pending shadow write
        mode = 1;
        tick();
        cfg8.cfg_valid = 1; cfg8.cfg_ch = 2'd1; cfg8.cfg_sel = 3'd3;
        tick();
        cfg8.cfg_valid = 0; mode = 0; rst = 1;
        tick();
        rst = 0;
        check("midrst_sel", sel8, bank(0, 1, 2));
        check("midrst_out", out8, 0);
        check("midrst_wrap", wrap8, 0);
        cfg8.commit = 1;
        tick();
        cfg8.commit = 0;
        check("shadow_discard", sel8, bank(0, 1, 2));

        // Dwell lowered below the running count steps on the next edge
        mode = 1; dwell = 8'd5;
        tick(); tick(); tick(); tick();
        check("dwell_pre", sel8, bank(0, 1, 2));
        dwell = 8'd1;
        tick();
        check("dwell_shrink", sel8, bank(1, 2, 3));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule
